// File: rtl/rca_bist_pkg.sv
// Shared definitions for the ripple-carry adder BIST response analyser:
// MISR width/taps, ORA state encoding and the MISR next-state function.
package rca_bist_pkg;

    localparam int          MISR_W    = 6;
    // x^6 + x^5 + 1 in internal-XOR form: feedback enters bit 0 and bit 5.
    localparam logic [5:0]  POLY_TAPS = 6'b100001;

    typedef enum logic [1:0] {
        COMPACT = 2'b00,
        CHECK   = 2'b01,
        DONE    = 2'b10
    } ora_state_e;

    // One MISR step: shift left, fold the old MSB back through the taps,
    // then XOR in the parallel response vector.
    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0] q,
        input logic [MISR_W-1:0] d
    );
        logic fb;
        fb = q[MISR_W-1];
        misr_next = {q[MISR_W-2:0], 1'b0} ^ (fb ? POLY_TAPS : '0) ^ d;
    endfunction

endpackage

// File: rtl/rca_bist_ora_misr6.sv
// Six-bit multiple-input signature register. Holds only the shift/XOR
// register; sequencing is decided by the enclosing analyser.
module misr6
    import rca_bist_pkg::*;
(
    input  logic              clk,
    input  logic              init,
    input  logic              load_en,
    input  logic [MISR_W-1:0] seed,
    input  logic [MISR_W-1:0] d,
    output logic [MISR_W-1:0] q
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    // Next signature: compact d when enabled, otherwise hold.
    always_comb begin
        sig_d = sig_q;
        if (load_en) begin
            sig_d = misr_next(sig_q, d);
        end
    end

    // Signature register; init reloads the seed and beats load_en.
    always_ff @(posedge clk) begin
        if (init) begin
            sig_q <= seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign q = sig_q;

endmodule

// File: rtl/rca_bist_ora.sv
// Output response analyser for the 5-bit ripple-carry adder BIST loop.
// Compacts {c_out, s} into a MISR for N_PATTERNS strobes, then compares
// the signature against GOLDEN and latches pass/fail until init.
module rca_bist_ora
    import rca_bist_pkg::*;
#(
    parameter int unsigned N_PATTERNS = 32,
    parameter logic [5:0]  SEED       = 6'h00,
    parameter logic [5:0]  GOLDEN     = 6'h00
) (
    input  logic       clk,
    input  logic       init,
    input  logic       en,
    input  logic [4:0] s,
    input  logic       c_out,
    output logic [5:0] signature,
    output logic [7:0] count,
    output logic       done,
    output logic       pass,
    output logic       fail
);

    // Pattern count at which the run ends; N_PATTERNS is limited to 1..255.
    localparam logic [7:0] LAST_COUNT = 8'(N_PATTERNS);

    ora_state_e  state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;

    logic        misr_load;
    logic        misr_clear;
    logic [5:0]  misr_q;
    logic [5:0]  resp;

    assign resp = {c_out, s};

    // Sequencing: count strobes while compacting, judge once, then freeze.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        misr_load  = 1'b0;
        misr_clear = 1'b0;
        case (state_q)
            COMPACT: begin
                if (en) begin
                    misr_load = 1'b1;
                    count_d   = count_q + 8'd1;
                    if (count_q + 8'd1 == LAST_COUNT) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                done_d  = 1'b1;
                pass_d  = (misr_q == GOLDEN);
                fail_d  = (misr_q != GOLDEN);
                state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                // Illegal encoding: behave as if init had been seen.
                state_d    = COMPACT;
                count_d    = 8'd0;
                done_d     = 1'b0;
                pass_d     = 1'b0;
                fail_d     = 1'b0;
                misr_clear = 1'b1;
            end
        endcase
    end

    // State, counter and verdict registers with init taking priority.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= COMPACT;
            count_q <= 8'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    misr6 u_misr (
        .clk     (clk),
        .init    (init | misr_clear),
        .load_en (misr_load),
        .seed    (SEED),
        .d       (resp),
        .q       (misr_q)
    );

    assign signature = misr_q;
    assign count     = count_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;

endmodule
